multi_dataflow_engine: RTL

MULTI_DATAFLOW_ENGINE -- requirements
Module: multi_dataflow_engine

---
 rtl/multi_dataflow_package.sv | 28 ++
 rtl/multi_dataflow_kernel.sv | 38 +++
 rtl/multi_dataflow_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/multi_dataflow_package.sv
// Shared types for the multi-dataflow engine: control/flag bundles and the FSM state encoding.
package multi_dataflow_package;

  localparam int CNT_LEN = 1024;
  localparam int CNT_W   = $clog2(CNT_LEN) + 1;

  typedef struct packed {
    logic             clear;
    logic             enable;
    logic             start;
    logic [CNT_W-1:0] cnt_limit_out_pel;
  } ctrl_engine_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt_out_pel;
    logic             done;
    logic             ready;
  } flags_engine_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_SIZE = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } engine_state_t;

endpackage

// File: rtl/multi_dataflow_kernel.sv
// Shift datapath plus the single-entry output register of the out_pel stream.
module multi_dataflow_kernel #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [4:0]            i_shift,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // A load in the same cycle as a pop refills the register, keeping 1 beat/cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data >> i_shift;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/multi_dataflow_engine.sv
// Job controller: size load, bounded pixel acceptance, drain and done pulse around the shift kernel.
module multi_dataflow_engine
  import multi_dataflow_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_LEN    = multi_dataflow_package::CNT_LEN
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   in_pel_data_i,
  input  logic                    in_pel_valid_i,
  output logic                    in_pel_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_size_data_i,
  input  logic                    in_size_valid_i,
  output logic                    in_size_ready_o,
  output logic [DATA_WIDTH-1:0]   out_pel_data_o,
  output logic [DATA_WIDTH/8-1:0] out_pel_strb_o,
  output logic                    out_pel_valid_o,
  input  logic                    out_pel_ready_i,
  input  ctrl_engine_t            ctrl_i,
  output flags_engine_t           flags_o
);

  localparam int CW = $clog2(CNT_LEN) + 1;

  engine_state_t r_state, w_next;
  logic [CW-1:0] r_limit, r_acc, r_cnt_out, w_lim_in;
  logic [4:0]    r_shift;
  logic          w_en, w_start, w_size_fire, w_in_fire, w_out_fire, w_out_valid;
  logic          w_pel_ready, w_size_ready, w_done, w_ready;
  logic          w_unused_size;

  assign w_en          = ctrl_i.enable;
  assign w_lim_in      = CW'(ctrl_i.cnt_limit_out_pel);
  assign w_start       = w_en & ctrl_i.start & (r_state == IDLE);
  assign w_size_fire   = w_size_ready & in_size_valid_i;
  assign w_in_fire     = w_pel_ready & in_pel_valid_i;
  // Downstream transfers only count while enabled, so a disabled engine holds its beat.
  assign w_out_fire    = w_en & w_out_valid & out_pel_ready_i;
  assign w_unused_size = ^in_size_data_i[DATA_WIDTH-1:5];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              r_state <= IDLE;
    else if (ctrl_i.clear)  r_state <= IDLE;
    else                    r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_en) begin
      case (r_state)
        IDLE:      if (ctrl_i.start) w_next = (w_lim_in != '0) ? LOAD_SIZE : DONE;
        LOAD_SIZE: if (w_size_fire) w_next = RUN;
        RUN:       if (r_acc == r_limit) w_next = DRAIN;
        DRAIN:     if (r_cnt_out == r_limit) w_next = DONE;
        DONE:      w_next = IDLE;
        default:   w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_size_ready = 1'b0;
    w_pel_ready  = 1'b0;
    w_done       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE:      w_ready      = 1'b1;
      LOAD_SIZE: w_size_ready = w_en;
      RUN:       w_pel_ready  = w_en & (r_acc < r_limit) & (~w_out_valid | out_pel_ready_i);
      DONE:      w_done       = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_limit   <= '0;
      r_acc     <= '0;
      r_cnt_out <= '0;
      r_shift   <= '0;
    end else if (ctrl_i.clear) begin
      r_limit   <= '0;
      r_acc     <= '0;
      r_cnt_out <= '0;
      r_shift   <= '0;
    end else if (w_start) begin
      r_limit   <= w_lim_in;
      r_acc     <= '0;
      r_cnt_out <= '0;
    end else begin
      if (w_size_fire) r_shift <= in_size_data_i[4:0];
      if (w_in_fire)   r_acc   <= r_acc + 1'b1;
      if (w_out_fire && r_cnt_out != '1) r_cnt_out <= r_cnt_out + 1'b1;
    end
  end

  multi_dataflow_kernel #(.DATA_WIDTH(DATA_WIDTH)) u_kernel (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_clear (ctrl_i.clear),
    .i_load  (w_in_fire),
    .i_pop   (w_out_fire),
    .i_data  (in_pel_data_i),
    .i_shift (r_shift),
    .o_valid (w_out_valid),
    .o_data  (out_pel_data_o)
  );

  assign in_pel_ready_o      = w_pel_ready;
  assign in_size_ready_o     = w_size_ready;
  assign out_pel_valid_o     = w_out_valid;
  assign out_pel_strb_o      = '1;
  assign flags_o.cnt_out_pel = CNT_W'(r_cnt_out);
  assign flags_o.done        = w_done;
  assign flags_o.ready       = w_ready;

endmodule
